lsu_mem_responder: RTL
======================

Name: lsu_mem_responder

Overview:
- Responder end of the LSU data-memory valid/ready protocol.
- Accepts read and write requests from NUM_CONSUMERS LSUs and multiplexes them onto NUM_CHANNELS data-memory ports.
- Returns ready, plus read data for loads, to each LSU.
- Sits between the per-thread LSUs of a core and the external data memory.

Parameters:
- ADDR_BITS, 8, address width
- DATA_BITS, 8, data width
- NUM_CONSUMERS, 4, number of LSUs served (≥2)
- NUM_CHANNELS, 1, concurrent memory ports (1..NUM_CONSUMERS)

Ports:
- clk  in  1  clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- consumer_read_valid  in  NUM_CONSUMERS  per-LSU load request
- consumer_read_address  in  NUM_CONSUMERS*ADDR_BITS  load addresses, packed
- consumer_read_ready  out  NUM_CONSUMERS  load complete
- consumer_read_data  out  NUM_CONSUMERS*DATA_BITS  load data, packed
- consumer_write_valid  in  NUM_CONSUMERS  per-LSU store request
- consumer_write_address  in  NUM_CONSUMERS*ADDR_BITS  store addresses
- consumer_write_data  in  NUM_CONSUMERS*DATA_BITS  store data
- consumer_write_ready  out  NUM_CONSUMERS  store complete
- mem_read_valid  out  NUM_CHANNELS  memory read request
- mem_read_address  out  NUM_CHANNELS*ADDR_BITS
- mem_read_ready  in  NUM_CHANNELS
- mem_read_data  in  NUM_CHANNELS*DATA_BITS
- mem_write_valid  out  NUM_CHANNELS
- mem_write_address  out  NUM_CHANNELS*ADDR_BITS
- mem_write_data  out  NUM_CHANNELS*DATA_BITS
- mem_write_ready  in  NUM_CHANNELS

Behaviour:
- Reset: reset_n low asynchronously clears every output, all channel FSMs (IDLE), the claimed mask, and rr_ptr (0).
  - A mid-transaction reset drops the outstanding memory request. No ready is issued for it.
- Consumer protocol:
  - Valid, address and data are held until the LSU samples ready=1. The LSU drops valid the following cycle.
  - The responder holds ready high until it samples valid low.
- Per-channel FSM states: IDLE, READ_WAIT, WRITE_WAIT, READ_RELAY, WRITE_RELAY.
- Arbitration:
  - At most one new grant per cycle.
  - Candidates are unclaimed consumers with read or write valid.
  - Search round-robin starting at rr_ptr; the first candidate found wins.
  - The winner goes to the lowest-index IDLE channel. No grant occurs if no channel is IDLE.
  - On grant, rr_ptr <= winner+1, wrapping modulo NUM_CONSUMERS.
  - The winner's claimed bit is set.
  - If a consumer asserts both read and write valid, read is granted; write stays pending.
- IDLE -> READ_WAIT on grant:
  - mem_read_valid <= 1, mem_read_address <= consumer address, both registered on the grant edge.
- READ_WAIT, on mem_read_ready=1:
  - mem_read_valid <= 0.
  - consumer_read_data[c] <= mem_read_data.
  - consumer_read_ready[c] <= 1.
  - Go to READ_RELAY.
- READ_RELAY, when consumer_read_valid[c]=0:
  - consumer_read_ready[c] <= 0, claimed[c] <= 0, go to IDLE.
  - The consumer is eligible for grant the next cycle.
- WRITE_WAIT and WRITE_RELAY mirror the read path using mem_write_* and consumer_write_*. Write data is latched on grant.
- consumer_read_data[c] holds its last value after ready falls.
- Latency, zero-wait memory (mem ready asserted the cycle after valid):
  - consumer valid sampled at edge 0
  - mem valid high after edge 0
  - consumer ready high after edge 2
- Memory ready while a channel is IDLE or in a RELAY state is ignored.
- A claimed consumer is never re-granted. A given consumer occupies at most one channel.
- A consumer dropping valid while in READ_WAIT/WRITE_WAIT is a protocol violation: the transaction still completes.
- Address and data widths pass through unchanged; there is no arithmetic.

Test Plan:
- Reset values: reset_n low mid-READ_WAIT, then high. All outputs 0, channel IDLE, rr_ptr 0; a subsequent request by consumer 0 is granted normally.
- Single read: consumer 0 reads addr 0x12; memory returns 0xA5 one cycle after mem_read_valid. consumer_read_ready[0]=1 with data 0xA5 two edges after request; ready drops one edge after valid drops.
- Single write: consumer 2 writes 0x7E to addr 0x40. mem_write_address=0x40, mem_write_data=0x7E; consumer_write_ready[2] pulses through the RELAY handshake.
- Round-robin, NUM_CHANNELS=1: consumers 0..3 all read simultaneously with addresses 0x00..0x03. Grant order is 0,1,2,3; each consumer receives the data returned for its own address.
- Concurrency, NUM_CHANNELS=2: consumers 1 and 3 request. Consumer 1 goes to channel 0 and consumer 3 to channel 1 on consecutive cycles. Memory stalls channel 0 for 5 cycles; consumer 3 completes first.
- Simultaneous read+write: consumer 1 asserts both. The read completes first, then the write is granted after the read's RELAY exits.

Source files
------------

// File: rtl/lsu_mem_responder.sv
// Responder side of the LSU data-memory valid/ready protocol: round-robin
// arbitration of NUM_CONSUMERS LSUs onto NUM_CHANNELS memory ports.

module lsu_mem_chan #(
  parameter int ADDR_BITS = 8,
  parameter int DATA_BITS = 8,
  parameter int CW        = 2
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 grant,
  input  logic                 grant_write,
  input  logic [CW-1:0]        grant_id,
  input  logic [ADDR_BITS-1:0] grant_addr,
  input  logic [DATA_BITS-1:0] grant_data,
  input  logic                 owner_read_valid,
  input  logic                 owner_write_valid,
  input  logic                 mem_read_ready,
  input  logic                 mem_write_ready,
  output logic                 idle,
  output logic [CW-1:0]        owner,
  output logic                 rd_done,
  output logic                 wr_done,
  output logic                 rd_exit,
  output logic                 wr_exit,
  output logic                 mem_read_valid,
  output logic [ADDR_BITS-1:0] mem_read_address,
  output logic                 mem_write_valid,
  output logic [ADDR_BITS-1:0] mem_write_address,
  output logic [DATA_BITS-1:0] mem_write_data
);
  typedef enum logic [2:0] {IDLE, READ_WAIT, WRITE_WAIT, READ_RELAY, WRITE_RELAY} state_t;
  state_t state, state_nxt;

  assign idle = (state == IDLE);

  always_comb begin
    state_nxt = state;
    rd_done   = 1'b0;
    wr_done   = 1'b0;
    rd_exit   = 1'b0;
    wr_exit   = 1'b0;
    case (state)
      IDLE:        if (grant) state_nxt = grant_write ? WRITE_WAIT : READ_WAIT;
      READ_WAIT:   if (mem_read_ready) begin rd_done = 1'b1; state_nxt = READ_RELAY; end
      WRITE_WAIT:  if (mem_write_ready) begin wr_done = 1'b1; state_nxt = WRITE_RELAY; end
      READ_RELAY:  if (!owner_read_valid) begin rd_exit = 1'b1; state_nxt = IDLE; end
      WRITE_RELAY: if (!owner_write_valid) begin wr_exit = 1'b1; state_nxt = IDLE; end
      default:     state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state             <= IDLE;
      owner             <= '0;
      mem_read_valid    <= 1'b0;
      mem_read_address  <= '0;
      mem_write_valid   <= 1'b0;
      mem_write_address <= '0;
      mem_write_data    <= '0;
    end else begin
      state <= state_nxt;
      if (grant && idle) begin
        owner <= grant_id;
        if (grant_write) begin
          mem_write_valid   <= 1'b1;
          mem_write_address <= grant_addr;
          mem_write_data    <= grant_data;
        end else begin
          mem_read_valid   <= 1'b1;
          mem_read_address <= grant_addr;
        end
      end
      if (rd_done) mem_read_valid  <= 1'b0;
      if (wr_done) mem_write_valid <= 1'b0;
    end
  end
endmodule

module lsu_mem_responder #(
  parameter int ADDR_BITS     = 8,
  parameter int DATA_BITS     = 8,
  parameter int NUM_CONSUMERS = 4,
  parameter int NUM_CHANNELS  = 1
) (
  input  logic                                        clk,
  input  logic                                        reset_n,
  input  logic [NUM_CONSUMERS-1:0]                    consumer_read_valid,
  input  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0]     consumer_read_address,
  output logic [NUM_CONSUMERS-1:0]                    consumer_read_ready,
  output logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0]     consumer_read_data,
  input  logic [NUM_CONSUMERS-1:0]                    consumer_write_valid,
  input  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0]     consumer_write_address,
  input  logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0]     consumer_write_data,
  output logic [NUM_CONSUMERS-1:0]                    consumer_write_ready,
  output logic [NUM_CHANNELS-1:0]                     mem_read_valid,
  output logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]      mem_read_address,
  input  logic [NUM_CHANNELS-1:0]                     mem_read_ready,
  input  logic [NUM_CHANNELS-1:0][DATA_BITS-1:0]      mem_read_data,
  output logic [NUM_CHANNELS-1:0]                     mem_write_valid,
  output logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]      mem_write_address,
  output logic [NUM_CHANNELS-1:0][DATA_BITS-1:0]      mem_write_data,
  input  logic [NUM_CHANNELS-1:0]                     mem_write_ready
);
  localparam int CW  = $clog2(NUM_CONSUMERS);
  localparam int CHW = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;

  logic [CW-1:0]                    rr_ptr, winner, idx;
  logic [NUM_CONSUMERS-1:0]         claimed, cand;
  logic                             found, any_idle, grant_vld, win_write;
  logic [CHW-1:0]                   ch_sel;
  logic [NUM_CHANNELS-1:0]          ch_idle, ch_grant, rd_done, wr_done, rd_exit, wr_exit;
  logic [NUM_CHANNELS-1:0]          owner_rv, owner_wv;
  logic [NUM_CHANNELS-1:0][CW-1:0]  ch_owner;
  logic [ADDR_BITS-1:0]             grant_addr;

  assign cand = ~claimed & (consumer_read_valid | consumer_write_valid);

  // Round-robin search from rr_ptr; first unclaimed requester wins.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    idx    = '0;
    for (int i = 0; i < NUM_CONSUMERS; i++) begin
      idx = CW'((int'(rr_ptr) + i) % NUM_CONSUMERS);
      if (!found && cand[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

  always_comb begin
    any_idle = 1'b0;
    ch_sel   = '0;
    for (int k = NUM_CHANNELS-1; k >= 0; k--)
      if (ch_idle[k]) begin any_idle = 1'b1; ch_sel = CHW'(k); end
  end

  assign grant_vld  = found && any_idle;
  // Reads take priority when an LSU raises both valids.
  assign win_write  = !consumer_read_valid[winner];
  assign grant_addr = win_write ? consumer_write_address[winner] : consumer_read_address[winner];

  always_comb begin
    ch_grant = '0;
    for (int k = 0; k < NUM_CHANNELS; k++) ch_grant[k] = grant_vld && (ch_sel == CHW'(k));
  end

  for (genvar k = 0; k < NUM_CHANNELS; k++) begin : gen_ch
    assign owner_rv[k] = consumer_read_valid[ch_owner[k]];
    assign owner_wv[k] = consumer_write_valid[ch_owner[k]];
    lsu_mem_chan #(.ADDR_BITS(ADDR_BITS), .DATA_BITS(DATA_BITS), .CW(CW)) u_chan (
      .clk               (clk),
      .reset_n           (reset_n),
      .grant             (ch_grant[k]),
      .grant_write       (win_write),
      .grant_id          (winner),
      .grant_addr        (grant_addr),
      .grant_data        (consumer_write_data[winner]),
      .owner_read_valid  (owner_rv[k]),
      .owner_write_valid (owner_wv[k]),
      .mem_read_ready    (mem_read_ready[k]),
      .mem_write_ready   (mem_write_ready[k]),
      .idle              (ch_idle[k]),
      .owner             (ch_owner[k]),
      .rd_done           (rd_done[k]),
      .wr_done           (wr_done[k]),
      .rd_exit           (rd_exit[k]),
      .wr_exit           (wr_exit[k]),
      .mem_read_valid    (mem_read_valid[k]),
      .mem_read_address  (mem_read_address[k]),
      .mem_write_valid   (mem_write_valid[k]),
      .mem_write_address (mem_write_address[k]),
      .mem_write_data    (mem_write_data[k])
    );
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr               <= '0;
      claimed              <= '0;
      consumer_read_ready  <= '0;
      consumer_read_data   <= '0;
      consumer_write_ready <= '0;
    end else begin
      if (grant_vld) begin
        rr_ptr          <= (int'(winner) == NUM_CONSUMERS-1) ? '0 : winner + 1'b1;
        claimed[winner] <= 1'b1;
      end
      // A consumer lives on at most one channel, so these never collide.
      for (int k = 0; k < NUM_CHANNELS; k++) begin
        if (rd_done[k]) begin
          consumer_read_ready[ch_owner[k]] <= 1'b1;
          consumer_read_data[ch_owner[k]]  <= mem_read_data[k];
        end
        if (wr_done[k]) consumer_write_ready[ch_owner[k]] <= 1'b1;
        if (rd_exit[k]) begin
          consumer_read_ready[ch_owner[k]] <= 1'b0;
          claimed[ch_owner[k]]             <= 1'b0;
        end
        if (wr_exit[k]) begin
          consumer_write_ready[ch_owner[k]] <= 1'b0;
          claimed[ch_owner[k]]              <= 1'b0;
        end
      end
    end
  end
endmodule
